// File: rtl/instr_mem_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_pkg
//   Shared types and sizing helpers for the banked instruction memory wrapper.
//   region_e  : which macro family a request targets (boot ROM or SRAM).
//   s1_tag_t  : per-request tag captured at the grant edge. It tells the
//               response stage which macro output to forward, or whether to
//               return zero data (writes, errors).
// -----------------------------------------------------------------------------
package instr_mem_pkg;

   typedef enum logic {
      REG_ROM = 1'b0,
      REG_RAM = 1'b1
   } region_e;

   // Fixed-width bank field keeps the tag struct parameter-free; it bounds
   // NUM_BANKS to 2**MAX_BANK_BITS.
   localparam int MAX_BANK_BITS = 4;

   typedef struct packed {
      logic                     valid;
      region_e                  region;
      logic [MAX_BANK_BITS-1:0] bank;
      logic                     we;
      logic                     err;
   } s1_tag_t;

   // Number of address bits that select a bank (0 for a single bank).
   function automatic int bank_bits(input int num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 0;
   endfunction

   // Byte-address width of one bank.
   function automatic int bank_aw(input int ram_size, input int num_banks);
      return $clog2(ram_size / num_banks);
   endfunction

endpackage

// File: rtl/instr_mem_banked_if.sv
// -----------------------------------------------------------------------------
// instr_mem_banked_if
//   Request/grant + valid/ready response bus of the instruction memory.
//   Request : req_i, gnt_o, addr_i, we_i, be_i, wdata_i
//   Response: rvalid_o, rready_i, rdata_o, err_o
//   Signal names carry the memory's point of view (_i = into the memory).
//   master : the core / bus bridge side.  slave : the memory side.
// -----------------------------------------------------------------------------
interface instr_mem_banked_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic                    req_i;
   logic                    gnt_o;
   logic [ADDR_WIDTH-1:0]   addr_i;
   logic                    we_i;
   logic [DATA_WIDTH/8-1:0] be_i;
   logic [DATA_WIDTH-1:0]   wdata_i;
   logic                    rvalid_o;
   logic                    rready_i;
   logic [DATA_WIDTH-1:0]   rdata_o;
   logic                    err_o;

   modport master (
      output req_i, addr_i, we_i, be_i, wdata_i, rready_i,
      input  gnt_o, rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, addr_i, we_i, be_i, wdata_i, rready_i,
      output gnt_o, rvalid_o, rdata_o, err_o
   );
endinterface

// File: rtl/boot_rom_wrap.sv
// -----------------------------------------------------------------------------
// boot_rom_wrap
//   Boot ROM macro wrapper, one-cycle registered read. The image is a fixed
//   pattern: word n holds 0xB007_0000 | n.
//   clk, rst_n : clock, async active-low reset
//   en_i       : read enable
//   addr_i     : word address
//   rdata_o    : read data (valid the cycle after en_i)
// -----------------------------------------------------------------------------
module boot_rom_wrap #(
   parameter int ROM_ADDR_WIDTH = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int WORD_AW        = ROM_ADDR_WIDTH - $clog2(DATA_WIDTH / 8)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  logic [WORD_AW-1:0]    addr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_o <= '0;
      end else if (en_i) begin
         rdata_o <= DATA_WIDTH'(32'hB007_0000) | DATA_WIDTH'(addr_i);
      end
   end
endmodule

// File: rtl/instr_mem_resp_buf.sv
// -----------------------------------------------------------------------------
// instr_mem_resp_buf
//   Response side of the instruction memory: s1 tag register, one-entry hold
//   buffer, grant stall and response mux.
//   i_req, o_gnt        : incoming request / grant (stalls on back-pressure)
//   i_tag               : decoded request tag, captured on grant
//   i_rom_rdata         : boot ROM read data
//   i_ram_rdata         : per-bank SRAM read data
//   i_rready            : response consumed
//   o_rvalid/o_rdata/o_err : response channel
// -----------------------------------------------------------------------------
module instr_mem_resp_buf
   import instr_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_BANKS  = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                i_req,
   input  s1_tag_t                             i_tag,
   output logic                                o_gnt,
   input  logic                                i_rready,
   input  logic [DATA_WIDTH-1:0]               i_rom_rdata,
   input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] i_ram_rdata,
   output logic                                o_rvalid,
   output logic [DATA_WIDTH-1:0]               o_rdata,
   output logic                                o_err
);
   s1_tag_t               r_s1;
   logic                  r_hold_valid;
   logic                  r_hold_err;
   logic [DATA_WIDTH-1:0] r_hold_rdata;
   logic [DATA_WIDTH-1:0] w_ram_sel;
   logic [DATA_WIDTH-1:0] w_s1_rdata;

   // A new request may enter only if the pipeline slot frees this cycle:
   // nothing held, and any s1 response is being consumed right now.
   assign o_gnt = i_req & ~r_hold_valid & ~(r_s1.valid & ~i_rready);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_ram_sel = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (r_s1.bank == MAX_BANK_BITS'(b)) w_ram_sel = i_ram_rdata[b];
      end
      w_s1_rdata = '0;
      if (r_s1.valid && !r_s1.we && !r_s1.err) begin
         w_s1_rdata = (r_s1.region == REG_ROM) ? i_rom_rdata : w_ram_sel;
      end
   end

   // Macro outputs are only guaranteed for the cycle after the access, so an
   // unconsumed s1 response is copied into the hold register.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1         <= '0;
         r_hold_valid <= 1'b0;
         r_hold_err   <= 1'b0;
         r_hold_rdata <= '0;
      end else begin
         if (o_gnt) r_s1 <= i_tag;
         else       r_s1.valid <= 1'b0;

         if (r_hold_valid) begin
            if (i_rready) r_hold_valid <= 1'b0;
         end else if (r_s1.valid && !i_rready) begin
            r_hold_valid <= 1'b1;
            r_hold_rdata <= w_s1_rdata;
            r_hold_err   <= r_s1.err;
         end
      end
   end

   assign o_rvalid = r_hold_valid | r_s1.valid;
   assign o_rdata  = r_hold_valid ? r_hold_rdata : w_s1_rdata;
   assign o_err    = r_hold_valid ? r_hold_err   : (r_s1.valid & r_s1.err);
endmodule

// File: rtl/sp_ram_wrap.sv
// -----------------------------------------------------------------------------
// sp_ram_wrap
//   Single-port SRAM macro wrapper, one-cycle registered read.
//   clk, rstn_i       : clock, async active-low reset (output register only)
//   en_i, we_i, be_i  : access enable, write, byte enables
//   addr_i            : word address
//   wdata_i / rdata_o : write data / read data (valid the cycle after en_i)
//   bypass_en_i       : test bypass, read port returns the write bus
// -----------------------------------------------------------------------------
module sp_ram_wrap #(
   parameter int RAM_SIZE   = 16384,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = $clog2(RAM_SIZE / (DATA_WIDTH / 8))
) (
   input  logic                    clk,
   input  logic                    rstn_i,
   input  logic                    en_i,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   input  logic                    bypass_en_i
);
   localparam int DEPTH = RAM_SIZE / (DATA_WIDTH / 8);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // NOTE: the storage array has no reset so it maps onto a RAM macro;
   // only the output register is reset.
   always_ff @(posedge clk) begin
      if (en_i && we_i) begin
         for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (be_i[b]) r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         rdata_o <= '0;
      end else if (en_i && !we_i) begin
         rdata_o <= bypass_en_i ? wdata_i : r_mem[addr_i];
      end
   end
endmodule

// File: rtl/instr_mem_banked.sv
// -----------------------------------------------------------------------------
// instr_mem_banked
//   Instruction memory wrapper: boot ROM in the lower address half, NUM_BANKS
//   contiguous SRAM banks in the upper half, behind one req/gnt port with a
//   valid/ready response channel. ROM writes and accesses beyond the ROM size
//   return err_o=1 without touching any macro.
//   clk, rst_n   : clock, async active-low reset
//   bypass_en_i  : SRAM test bypass, forwarded to every bank
//   bus          : instr_mem_banked_if.slave request/response bus
// -----------------------------------------------------------------------------
module instr_mem_banked
   import instr_mem_pkg::*;
#(
   parameter int RAM_SIZE       = 32768,
   parameter int NUM_BANKS      = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int ROM_ADDR_WIDTH = 12,
   parameter int ADDR_WIDTH     = $clog2(RAM_SIZE) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               bypass_en_i,
   instr_mem_banked_if.slave  bus
);
   localparam int BANK_BITS = bank_bits(NUM_BANKS);
   localparam int BANK_AW   = bank_aw(RAM_SIZE, NUM_BANKS);
   localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);
   localparam int AW        = ADDR_WIDTH;

   logic                                 w_is_rom;
   logic                                 w_err;
   logic                                 w_gnt;
   logic                                 w_rom_en;
   logic [NUM_BANKS-1:0]                 w_ram_en;
   logic [MAX_BANK_BITS-1:0]             w_bank;
   s1_tag_t                              w_tag;
   logic [DATA_WIDTH-1:0]                w_rom_rdata;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_ram_rdata;
   logic                                 w_unused;

   // Address decode. Shifting away the bank offset yields the bank index and
   // collapses to 0 when there is a single bank.
   assign w_is_rom = ~bus.addr_i[AW-1];
   assign w_err    = w_is_rom & ((|bus.addr_i[AW-2:ROM_ADDR_WIDTH]) | bus.we_i);
   assign w_bank   = MAX_BANK_BITS'(bus.addr_i[AW-2:0] >> BANK_AW);
   assign w_unused = ^bus.addr_i[BYTE_BITS-1:0];

   always_comb begin
      w_tag        = '0;
      w_tag.valid  = bus.req_i;
      w_tag.region = w_is_rom ? REG_ROM : REG_RAM;
      w_tag.bank   = w_is_rom ? '0 : w_bank;
      w_tag.we     = bus.we_i;
      w_tag.err    = w_err;
   end

   // Only a granted, error-free request enables exactly one macro.
   assign w_rom_en = w_gnt & w_is_rom & ~w_err;

   boot_rom_wrap #(
      .ROM_ADDR_WIDTH (ROM_ADDR_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH)
   ) u_rom (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (w_rom_en),
      .addr_i  (bus.addr_i[ROM_ADDR_WIDTH-1:BYTE_BITS]),
      .rdata_o (w_rom_rdata)
   );

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign w_ram_en[b] = w_gnt & ~w_is_rom & (w_bank == MAX_BANK_BITS'(b));

      sp_ram_wrap #(
         .RAM_SIZE   (RAM_SIZE / NUM_BANKS),
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (BANK_AW - BYTE_BITS)
      ) u_ram (
         .clk         (clk),
         .rstn_i      (rst_n),
         .en_i        (w_ram_en[b]),
         .we_i        (bus.we_i),
         .addr_i      (bus.addr_i[BANK_AW-1:BYTE_BITS]),
         .be_i        (bus.be_i),
         .wdata_i     (bus.wdata_i),
         .rdata_o     (w_ram_rdata[b]),
         .bypass_en_i (bypass_en_i)
      );
   end

   instr_mem_resp_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_BANKS  (NUM_BANKS)
   ) u_resp (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (bus.req_i),
      .i_tag       (w_tag),
      .o_gnt       (w_gnt),
      .i_rready    (bus.rready_i),
      .i_rom_rdata (w_rom_rdata),
      .i_ram_rdata (w_ram_rdata),
      .o_rvalid    (bus.rvalid_o),
      .o_rdata     (bus.rdata_o),
      .o_err       (bus.err_o)
   );

   assign bus.gnt_o = w_gnt;
endmodule

// File: tb/tb_instr_mem_banked.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_banked
//   Self-checking bench for instr_mem_banked (RAM_SIZE=32768, 2 banks, 4 KiB
//   ROM, 16-bit addresses). A reference model keeps an associative memory and
//   a queue of outstanding responses; every cycle it predicts gnt/rvalid and
//   the head response, and checks the macro enables for the granted access.
// -----------------------------------------------------------------------------
module tb_instr_mem_banked;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic bypass_en = 1'b0;

   always #5 clk = ~clk;

   instr_mem_banked_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

   instr_mem_banked #(
      .RAM_SIZE       (32768),
      .NUM_BANKS      (2),
      .DATA_WIDTH     (32),
      .ROM_ADDR_WIDTH (12)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bypass_en_i (bypass_en),
      .bus         (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   resp_t       exp_q[$];
   bit          front_fresh = 1'b0;
   logic [31:0] ram_m [int];
   logic [15:0] pool [16];

   logic        s_gnt, s_rvalid, s_err, s_rom_en;
   logic [31:0] s_rdata;
   logic [1:0]  s_ram_en;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: the spec-level effect of one granted access.
   task automatic predict(input logic [15:0] addr, input bit we, input logic [3:0] be,
                          input logic [31:0] wd, output resp_t r);
      int          key;
      logic [31:0] v;
      r = '0;
      if (!addr[15]) begin
         if (we || addr[14:12] != 3'd0) r.err = 1'b1;
         else                           r.rdata = 32'hB007_0000 | 32'(addr[11:2]);
      end else begin
         key = int'(addr & 16'hFFFC);
         v   = ram_m.exists(key) ? ram_m[key] : 32'h0;
         if (we) begin
            for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
            ram_m[key] = v;
         end else begin
            r.rdata = v;
         end
      end
   endtask

   // One clock cycle: drive at posedge+1, sample and score at negedge.
   task automatic step(input bit req, input logic [15:0] addr, input bit we,
                       input logic [3:0] be, input logic [31:0] wd, input bit rr);
      bit    exp_gnt;
      bit    consumed;
      resp_t r;
      logic [1:0] exp_ram_en;
      bus.req_i    = req;
      bus.addr_i   = addr;
      bus.we_i     = we;
      bus.be_i     = be;
      bus.wdata_i  = wd;
      bus.rready_i = rr;
      @(negedge clk);
      s_gnt    = bus.gnt_o;
      s_rvalid = bus.rvalid_o;
      s_rdata  = bus.rdata_o;
      s_err    = bus.err_o;
      s_ram_en = dut.w_ram_en;
      s_rom_en = dut.w_rom_en;

      // A slot is free if nothing is pending, or the single pending response
      // was produced last cycle, was never refused, and is taken now.
      exp_gnt = req && (exp_q.size() == 0 ||
                        (exp_q.size() == 1 && rr && front_fresh));
      check("gnt", 32'(s_gnt), 32'(exp_gnt));
      check("rvalid", 32'(s_rvalid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check("rdata", s_rdata, exp_q[0].rdata);
         check("err", 32'(s_err), 32'(exp_q[0].err));
      end else begin
         check("rdata_idle", s_rdata, 32'h0);
      end
      exp_ram_en = (s_gnt && addr[15]) ? (2'b01 << addr[14]) : 2'b00;
      check("ram_en", 32'(s_ram_en), 32'(exp_ram_en));
      check("rom_en", 32'(s_rom_en),
            32'(s_gnt && !addr[15] && !we && addr[14:12] == 3'd0));

      consumed = s_rvalid && rr && exp_q.size() != 0;
      if (exp_q.size() != 0 && !consumed) front_fresh = 1'b0;
      if (consumed) void'(exp_q.pop_front());
      if (s_gnt) begin
         predict(addr, we, be, wd, r);
         exp_q.push_back(r);
         front_fresh = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   // Repeat a request until granted, with a bounded wait.
   task automatic issue(input logic [15:0] addr, input bit we, input logic [3:0] be,
                        input logic [31:0] wd, input bit rr);
      bit done = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         step(1'b1, addr, we, be, wd, rr);
         done = s_gnt;
      end
      if (!done) check("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input bit rr);
      step(1'b0, 16'h0, 1'b0, 4'h0, 32'h0, rr);
   endtask

   task automatic async_reset_check(input string tag);
      bus.req_i = 1'b0;
      rst_n     = 1'b0;
      #2;
      check({tag, "_rvalid"}, 32'(bus.rvalid_o), 32'd0);
      check({tag, "_gnt"},    32'(bus.gnt_o),    32'd0);
      check({tag, "_err"},    32'(bus.err_o),    32'd0);
      check({tag, "_rdata"},  bus.rdata_o,       32'h0);
      exp_q.delete();
      front_fresh = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      bus.req_i    = 1'b0;
      bus.addr_i   = '0;
      bus.we_i     = 1'b0;
      bus.be_i     = '0;
      bus.wdata_i  = '0;
      bus.rready_i = 1'b0;
      #12;
      check("reset_rvalid", 32'(bus.rvalid_o), 32'd0);
      check("reset_gnt",    32'(bus.gnt_o),    32'd0);
      check("reset_err",    32'(bus.err_o),    32'd0);
      check("reset_rdata",  bus.rdata_o,       32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: write then read back, one-cycle latency each
      step(1'b1, 16'h8004, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1);
      check("t1_wr_gnt", 32'(s_gnt), 32'd1);
      step(1'b1, 16'h8004, 1'b0, 4'h0, 32'h0, 1'b1);
      check("t1_wr_ack_valid", 32'(s_rvalid), 32'd1);
      check("t1_wr_ack_rdata", s_rdata, 32'h0);
      check("t1_wr_ack_err",   32'(s_err), 32'd0);
      idle(1'b1);
      check("t1_rd_valid", 32'(s_rvalid), 32'd1);
      check("t1_rd_data",  s_rdata, 32'hDEAD_BEEF);

      // 2: one write per bank, only the addressed bank is enabled
      step(1'b1, 16'hC000, 1'b1, 4'hF, 32'h1111_1111, 1'b1);
      check("t2_bank1_en", 32'(s_ram_en), 32'h2);
      step(1'b1, 16'h8000, 1'b1, 4'hF, 32'h2222_2222, 1'b1);
      check("t2_bank0_en", 32'(s_ram_en), 32'h1);
      step(1'b1, 16'hC000, 1'b0, 4'h0, 32'h0, 1'b1);
      step(1'b1, 16'h8000, 1'b0, 4'h0, 32'h0, 1'b1);
      check("t2_rd_bank1", s_rdata, 32'h1111_1111);
      idle(1'b1);
      check("t2_rd_bank0", s_rdata, 32'h2222_2222);

      // 3: ROM read, ROM write-protect, ROM out-of-range
      step(1'b1, 16'h0000, 1'b0, 4'h0, 32'h0, 1'b1);
      check("t3_rom_en", 32'(s_rom_en), 32'd1);
      step(1'b1, 16'h0010, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1);
      check("t3_rom_word0", s_rdata, 32'hB007_0000);
      check("t3_wp_no_en", 32'({s_rom_en, s_ram_en}), 32'd0);
      step(1'b1, 16'h0010, 1'b0, 4'h0, 32'h0, 1'b1);
      check("t3_wp_err",   32'(s_err), 32'd1);
      step(1'b1, 16'h2000, 1'b0, 4'h0, 32'h0, 1'b1);
      check("t3_rom_unchanged", s_rdata, 32'hB007_0004);
      check("t3_oor_no_en", 32'({s_rom_en, s_ram_en}), 32'd0);
      idle(1'b1);
      check("t3_oor_err",   32'(s_err), 32'd1);
      check("t3_oor_rdata", s_rdata, 32'h0);

      // 4: back-pressure, held response stays stable, order preserved
      step(1'b1, 16'h8000, 1'b0, 4'h0, 32'h0, 1'b0);
      check("t4_first_gnt", 32'(s_gnt), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 16'h8004, 1'b0, 4'h0, 32'h0, 1'b0);
         check("t4_stall_gnt",  32'(s_gnt), 32'd0);
         check("t4_stall_data", s_rdata, 32'h2222_2222);
      end
      issue(16'h8004, 1'b0, 4'h0, 32'h0, 1'b1);
      idle(1'b1);
      check("t4_second_data", s_rdata, 32'hDEAD_BEEF);

      // 5: async reset with a held response, then with a response in s1
      step(1'b1, 16'h8000, 1'b0, 4'h0, 32'h0, 1'b0);
      step(1'b1, 16'h8004, 1'b0, 4'h0, 32'h0, 1'b0);
      async_reset_check("t5_hold");
      for (int i = 0; i < 3; i++) idle(1'b1);
      step(1'b1, 16'hC000, 1'b0, 4'h0, 32'h0, 1'b1);
      async_reset_check("t5_s1");
      for (int i = 0; i < 3; i++) idle(1'b1);

      // 6: randomized traffic against the reference model
      for (int i = 0; i < 16; i++) begin
         pool[i] = 16'h8000 | 16'($urandom & 32'h7FFC);
         issue(pool[i], 1'b1, 4'hF, $urandom, 1'b1);
      end
      for (int i = 0; i < 10000; i++) begin
         int          sel;
         logic [15:0] a;
         bit          w;
         sel = int'($urandom_range(0, 9));
         w   = ($urandom_range(0, 9) < 4);
         if (sel == 0) begin
            a = 16'($urandom & 32'h0FFC);
         end else if (sel == 1) begin
            a = 16'(($urandom_range(1, 7) << 12) | ($urandom & 32'h0FFC));
         end else begin
            a = pool[$urandom_range(0, 15)];
         end
         step($urandom_range(0, 9) < 6, a, w, 4'($urandom), $urandom,
              $urandom_range(0, 9) < 7);
      end
      for (int i = 0; i < 4 && exp_q.size() != 0; i++) idle(1'b1);
      check("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
